// File: rtl/stack_alu_pkg.sv
// Shared opcode, error-code and FSM-state constants for the stack ALU and its sequencer.
package stack_alu_pkg;

  localparam logic [2:0] OP_HALT = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  function automatic logic is_nop(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b010) || (op == 3'b011);
  endfunction

endpackage

// File: rtl/stack_alu_sequencer_timeout_ctr.sv
// Response-wait timer: clr marks the first waiting cycle, expired flags the TMO-th one.
// Latency: expired is combinational from the count register.
// Backpressure: none; counts only while en is high and saturates at TMO.
module seq_timeout_ctr #(
  parameter int TMO = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TMO + 1);

  // cnt holds the 1-based index of the current waiting cycle
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clr)              cnt <= CW'(1);
    else if (en && !expired)   cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == CW'(TMO));

endmodule

// File: rtl/stack_alu_sequencer.sv
// Fetches {op,imm} words from a sync ROM and issues them to the stack ALU; reports pops/faults.
// Latency: 3 cycles per push (fetch, decode, issue), plus response wait for add/mul/pop.
// Backpressure: alu_valid holds op/data stable until alu_ready; waits up to TMO cycles for a response.
module stack_alu_sequencer
  import stack_alu_pkg::*;
#(
  parameter int N     = 8,
  parameter int AW    = 6,
  parameter int DEPTH = 201,
  parameter int TMO   = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] prog_addr,
  input  logic [N+2:0]  prog_rdata,
  output logic          alu_valid,
  input  logic          alu_ready,
  output logic [2:0]    alu_op,
  output logic [N-1:0]  alu_data,
  input  logic          alu_rsp_valid,
  input  logic [N-1:0]  alu_rsp_data,
  input  logic          alu_rsp_ovf,
  output logic          res_valid,
  output logic [N-1:0]  res_data,
  output logic          ovf_sticky,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam int DW = $clog2(DEPTH + 1);

  logic [2:0]    state;
  logic [AW-1:0] pc;
  logic [DW-1:0] depth;
  logic [2:0]    op_q;
  logic [N-1:0]  imm_q;
  logic          armed;
  logic [2:0]    dec_op;
  logic [N-1:0]  dec_imm;
  logic          last;
  logic [2:0]    adv_state;
  logic          tmo_exp;

  assign {dec_op, dec_imm} = prog_rdata;
  assign prog_addr = pc;
  assign alu_valid = (state == S_ISSUE);
  assign alu_op    = op_q;
  assign alu_data  = imm_q;
  assign busy      = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign done      = (state == S_DONE);
  assign err       = (state == S_ERROR);

  // The top program word ends the run instead of wrapping back to address 0
  assign last      = &pc;
  assign adv_state = last ? S_DONE : S_FETCH;

  seq_timeout_ctr #(.TMO(TMO)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (alu_valid && alu_ready && (op_q != OP_PUSH)),
    .en      (state == S_RESP),
    .expired (tmo_exp)
  );

  // Blocks a start that coincides with the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= '0;
      depth      <= '0;
      op_q       <= '0;
      imm_q      <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      ovf_sticky <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      res_valid <= 1'b0;
      case (state)
        // A start from DONE/ERROR clears the run status and launches straight away
        S_IDLE, S_DONE, S_ERROR: begin
          if (start && armed) begin
            state      <= S_FETCH;
            pc         <= '0;
            depth      <= '0;
            ovf_sticky <= 1'b0;
            err_code   <= ERR_NONE;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          op_q  <= dec_op;
          imm_q <= (dec_op == OP_PUSH) ? dec_imm : '0;
          if (dec_op == OP_HALT) begin
            state <= S_DONE;
          end else if (is_nop(dec_op)) begin
            state <= adv_state;
            if (!last) pc <= pc + 1'b1;
          end else if ((dec_op == OP_PUSH) && (depth == DW'(DEPTH))) begin
            state    <= S_ERROR;
            err_code <= ERR_OVER;
          end else if (((dec_op == OP_POP) && (depth == '0)) ||
                       (((dec_op == OP_ADD) || (dec_op == OP_MUL)) && (depth < DW'(2)))) begin
            state    <= S_ERROR;
            err_code <= ERR_UNDER;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (alu_ready) begin
            if (op_q == OP_PUSH) begin
              depth <= depth + 1'b1;
              state <= adv_state;
              if (!last) pc <= pc + 1'b1;
            end else begin
              state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          // add/mul consume two and push one, so both they and pop net -1
          if (alu_rsp_valid) begin
            depth <= depth - 1'b1;
            if (op_q == OP_POP) begin
              res_valid <= 1'b1;
              res_data  <= alu_rsp_data;
            end else begin
              ovf_sticky <= ovf_sticky | alu_rsp_ovf;
            end
            state <= adv_state;
            if (!last) pc <= pc + 1'b1;
          end else if (tmo_exp) begin
            state    <= S_ERROR;
            err_code <= ERR_TMO;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
